// File: rtl/video_pkg.sv
// Shared constants for the double-buffered video path: screen geometry,
// scaled frame geometry, derived address widths and scheduler state codes.
package video_pkg;

    localparam int SCREEN_WIDTH  = 800;
    localparam int SCREEN_HEIGHT = 600;

    localparam int X_WIDTH  = 200;
    localparam int Y_HEIGHT = 150;

    localparam int X_ADDR_W = $clog2(X_WIDTH);
    localparam int Y_ADDR_W = $clog2(Y_HEIGHT);

    // Scheduler states, kept as plain constants for older tool flows.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;
    localparam logic [1:0] ST_FULL = 2'd3;

endpackage

// File: rtl/frame_addr_counter.sv
// Raster-order x/y write address for one scaled frame. Advances on each
// accepted pixel and wraps back to (0,0) after the last pixel.
module frame_addr_counter #(
    parameter int X_WIDTH  = 200,
    parameter int Y_HEIGHT = 150
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_advance,
    output logic [$clog2(X_WIDTH)-1:0]  o_x,
    output logic [$clog2(Y_HEIGHT)-1:0] o_y,
    output logic                        o_last
);

    localparam int XW = $clog2(X_WIDTH);
    localparam int YW = $clog2(Y_HEIGHT);
    localparam logic [XW-1:0] X_LAST = XW'(X_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_HEIGHT - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          w_x_end;
    logic          w_y_end;

    assign w_x_end = (r_x == X_LAST);
    assign w_y_end = (r_y == Y_LAST);

    // Address register: clear, or step x then y with wrap at the frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            if (w_x_end) begin
                r_x <= '0;
                r_y <= w_y_end ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = w_x_end && w_y_end;

endmodule

// File: rtl/frame_bank_scheduler.sv
// Double-buffer controller: fills the back bank from the pixel stream,
// drives the back bank write enable with the write address, and swaps
// banks on a VGA frame boundary once the back bank holds a full frame.
module frame_bank_scheduler #(
    parameter int X_WIDTH  = 200,
    parameter int Y_HEIGHT = 150,
    parameter int CNT_W    = 16
) (
    input  logic                        CLK_40,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        pixel_valid,
    input  logic                        frame_end,
    output logic                        frame_req,
    output logic                        video_bank1_we,
    output logic                        video_bank2_we,
    output logic [$clog2(X_WIDTH)-1:0]  mem_x_pos,
    output logic [$clog2(Y_HEIGHT)-1:0] mem_y_pos,
    output logic                        video_bank_sel,
    output logic                        filling,
    output logic [CNT_W-1:0]            repeat_cnt,
    output logic                        overrun
);

    import video_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic             r_frame_req;
    logic             r_filling;
    logic             r_bank_sel;
    logic [CNT_W-1:0] r_repeat_cnt;
    logic             r_overrun;

    logic             w_accept;
    logic             w_discard;
    logic             w_swap;
    logic             w_repeat;
    logic             w_last;
    logic             w_clear;

    // A pixel is written only while a fill is in progress; otherwise it is
    // dropped and flagged.
    assign w_accept  = pixel_valid && ((r_state == ST_REQ) || (r_state == ST_FILL));
    assign w_discard = pixel_valid && ((r_state == ST_IDLE) || (r_state == ST_FULL));
    assign w_swap    = frame_end && (r_state == ST_FULL);
    assign w_repeat  = frame_end && (r_state != ST_FULL) && enable;
    assign w_clear   = (r_state == ST_IDLE);

    frame_addr_counter #(
        .X_WIDTH  (X_WIDTH),
        .Y_HEIGHT (Y_HEIGHT)
    ) u_addr (
        .clk       (CLK_40),
        .rst       (reset),
        .i_clear   (w_clear),
        .i_advance (w_accept),
        .o_x       (mem_x_pos),
        .o_y       (mem_y_pos),
        .o_last    (w_last)
    );

    // Next-state logic; enable is only looked at in IDLE and when leaving FULL.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (enable) w_state_next = ST_REQ;
            ST_REQ:  if (w_accept) w_state_next = w_last ? ST_FULL : ST_FILL;
            ST_FILL: if (w_accept && w_last) w_state_next = ST_FULL;
            ST_FULL: if (frame_end) w_state_next = enable ? ST_REQ : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with Moore outputs derived from the next state.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame_req <= 1'b0;
            r_filling   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_frame_req <= (w_state_next == ST_REQ);
            r_filling   <= (w_state_next == ST_REQ) || (w_state_next == ST_FILL);
        end
    end

    // Bank swap happens only on a frame boundary with a complete back bank.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_bank_sel <= 1'b0;
        end else if (w_swap) begin
            r_bank_sel <= ~r_bank_sel;
        end
    end

    // Count displayed frames repeated because no new frame was ready.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_repeat_cnt <= '0;
        end else if (w_repeat && (r_repeat_cnt != CNT_MAX)) begin
            r_repeat_cnt <= r_repeat_cnt + 1'b1;
        end
    end

    // Sticky flag for pixels that arrived with nowhere to go.
    always_ff @(posedge CLK_40 or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_discard) begin
            r_overrun <= 1'b1;
        end
    end

    assign frame_req      = r_frame_req;
    assign filling        = r_filling;
    assign video_bank_sel = r_bank_sel;
    assign repeat_cnt     = r_repeat_cnt;
    assign overrun        = r_overrun;
    // The back bank is the one not on display; the front bank is never written.
    assign video_bank1_we = w_accept && !r_bank_sel;
    assign video_bank2_we = w_accept &&  r_bank_sel;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Directed bench for frame_bank_scheduler: full frame fills into each bank,
// swap timing, repeat counting with saturation, overrun and async reset.
module tb_frame_bank_scheduler;

    localparam int XW    = 200;
    localparam int YH    = 150;
    localparam int NPIX  = XW * YH;
    localparam int CW    = 3;

    logic          clk;
    logic          rst;
    logic          enable;
    logic          pixel_valid;
    logic          frame_end;
    logic          frame_req;
    logic          we1;
    logic          we2;
    logic [7:0]    x_pos;
    logic [7:0]    y_pos;
    logic          bank_sel;
    logic          filling;
    logic [CW-1:0] repeat_cnt;
    logic          overrun;

    int vectors;
    int miscompares;

    frame_bank_scheduler #(
        .X_WIDTH  (XW),
        .Y_HEIGHT (YH),
        .CNT_W    (CW)
    ) dut (
        .CLK_40         (clk),
        .reset          (rst),
        .enable         (enable),
        .pixel_valid    (pixel_valid),
        .frame_end      (frame_end),
        .frame_req      (frame_req),
        .video_bank1_we (we1),
        .video_bank2_we (we2),
        .mem_x_pos      (x_pos),
        .mem_y_pos      (y_pos),
        .video_bank_sel (bank_sel),
        .filling        (filling),
        .repeat_cnt     (repeat_cnt),
        .overrun        (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        logic [23:0] obs;
        rst = 1'b1; enable = 1'b0; pixel_valid = 1'b0; frame_end = 1'b0;
        #1;
        vectors++;
        obs = {frame_req, we1, we2, x_pos, y_pos, bank_sel, filling, repeat_cnt, overrun};
        if (obs !== 24'd0) begin
            miscompares++;
            $display("FAIL reset_values: got %h want 000000", obs);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_enable_req();
        enable = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({frame_req, filling, bank_sel, we1, we2} !== 5'b11000) begin
            miscompares++;
            $display("FAIL enable_req: got req=%b fill=%b sel=%b we=%b%b want 1 1 0 00",
                     frame_req, filling, bank_sel, we1, we2);
        end
        $display("test_enable_req done");
    endtask

    // Fill bank 1; repeat pulses at 100/200/300 and on the last pixel.
    task automatic test_fill_bank1();
        logic [17:0] obs, exp;
        for (int i = 0; i < NPIX; i++) begin
            pixel_valid = 1'b1;
            frame_end = (i == 100 || i == 200 || i == 300 || i == NPIX - 1);
            #1;
            vectors++;
            obs = {we1, we2, x_pos, y_pos};
            exp = {1'b1, 1'b0, 8'(i % XW), 8'(i / XW)};
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fill1_pixel %0d: got we=%b%b x=%0d y=%0d want we=10 x=%0d y=%0d",
                         i, we1, we2, x_pos, y_pos, i % XW, i / XW);
            end
            if (i == 1) begin
                vectors++;
                if ({frame_req, filling} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL fill1_req_drop: got req=%b fill=%b want 0 1", frame_req, filling);
                end
            end
            if (i == 301) begin
                vectors++;
                if ({repeat_cnt, bank_sel} !== {3'd3, 1'b0}) begin
                    miscompares++;
                    $display("FAIL repeat_midfill: got cnt=%0d sel=%b want 3 0", repeat_cnt, bank_sel);
                end
            end
            @(posedge clk); #1;
        end
        pixel_valid = 1'b0; frame_end = 1'b0;
        #1;
        vectors++;
        if ({filling, frame_req, bank_sel, repeat_cnt, x_pos, y_pos, we1, we2} !==
            {1'b0, 1'b0, 1'b0, 3'd4, 8'd0, 8'd0, 2'b00}) begin
            miscompares++;
            $display("FAIL fill1_full: got fill=%b req=%b sel=%b cnt=%0d x=%0d y=%0d want 0 0 0 4 0 0",
                     filling, frame_req, bank_sel, repeat_cnt, x_pos, y_pos);
        end
        @(posedge clk); #1;
        $display("test_fill_bank1 done");
    endtask

    task automatic test_swap();
        frame_end = 1'b1;
        #1;
        vectors++;
        if ({we1, we2, bank_sel} !== 3'b000) begin
            miscompares++;
            $display("FAIL swap_pre: got we=%b%b sel=%b want 00 0", we1, we2, bank_sel);
        end
        @(posedge clk); #1;
        frame_end = 1'b0;
        vectors++;
        if ({bank_sel, frame_req, filling, repeat_cnt, overrun} !== {1'b1, 1'b1, 1'b1, 3'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL swap_post: got sel=%b req=%b fill=%b cnt=%0d ovr=%b want 1 1 1 4 0",
                     bank_sel, frame_req, filling, repeat_cnt, overrun);
        end
        $display("test_swap done");
    endtask

    // Fill bank 2; saturate the repeat counter, drop enable mid-fill.
    task automatic test_fill_bank2();
        logic [17:0] obs, exp;
        for (int i = 0; i < NPIX; i++) begin
            pixel_valid = 1'b1;
            frame_end = (i == 1000 || i == 2000 || i == 3000 || i == 4000);
            if (i == 5000) enable = 1'b0;
            #1;
            vectors++;
            obs = {we1, we2, x_pos, y_pos};
            exp = {1'b0, 1'b1, 8'(i % XW), 8'(i / XW)};
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL fill2_pixel %0d: got we=%b%b x=%0d y=%0d want we=01 x=%0d y=%0d",
                         i, we1, we2, x_pos, y_pos, i % XW, i / XW);
            end
            if (i == 3500) begin
                vectors++;
                if (repeat_cnt !== 3'd7) begin
                    miscompares++;
                    $display("FAIL repeat_reach_max: got %0d want 7", repeat_cnt);
                end
            end
            @(posedge clk); #1;
        end
        pixel_valid = 1'b0; frame_end = 1'b0;
        #1;
        vectors++;
        if ({filling, frame_req, bank_sel, repeat_cnt} !== {1'b0, 1'b0, 1'b1, 3'd7}) begin
            miscompares++;
            $display("FAIL fill2_full: got fill=%b req=%b sel=%b cnt=%0d want 0 0 1 7",
                     filling, frame_req, bank_sel, repeat_cnt);
        end
        @(posedge clk); #1;
        $display("test_fill_bank2 done");
    endtask

    // frame_end together with a pixel in FULL: swap, drop, flag; enable=0 -> IDLE.
    task automatic test_swap_with_pixel();
        pixel_valid = 1'b1; frame_end = 1'b1;
        #1;
        vectors++;
        if ({we1, we2} !== 2'b00) begin
            miscompares++;
            $display("FAIL full_pixel_we: got we=%b%b want 00", we1, we2);
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0; frame_end = 1'b0;
        vectors++;
        if ({bank_sel, overrun, frame_req, filling} !== 4'b0100) begin
            miscompares++;
            $display("FAIL full_pixel_swap: got sel=%b ovr=%b req=%b fill=%b want 0 1 0 0",
                     bank_sel, overrun, frame_req, filling);
        end
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if ({overrun, frame_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL overrun_sticky: got ovr=%b req=%b want 1 0", overrun, frame_req);
        end
        $display("test_swap_with_pixel done");
    endtask

    task automatic test_reset_midfill();
        logic [23:0] obs;
        logic [17:0] pobs, pexp;
        enable = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12345; i++) begin
            pixel_valid = 1'b1;
            #1;
            vectors++;
            pobs = {we1, we2, x_pos, y_pos};
            pexp = {1'b1, 1'b0, 8'(i % XW), 8'(i / XW)};
            if (pobs !== pexp) begin
                miscompares++;
                $display("FAIL fill3_pixel %0d: got we=%b%b x=%0d y=%0d want we=10 x=%0d y=%0d",
                         i, we1, we2, x_pos, y_pos, i % XW, i / XW);
            end
            @(posedge clk); #1;
        end
        pixel_valid = 1'b1;
        #1;
        vectors++;
        if ({we1, x_pos, y_pos} !== {1'b1, 8'd145, 8'd61}) begin
            miscompares++;
            $display("FAIL pixel_12345: got we1=%b x=%0d y=%0d want 1 145 61", we1, x_pos, y_pos);
        end
        #1 rst = 1'b1;
        #1;
        vectors++;
        obs = {frame_req, we1, we2, x_pos, y_pos, bank_sel, filling, repeat_cnt, overrun};
        if (obs !== 24'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h want 000000", obs);
        end
        pixel_valid = 1'b0; enable = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        // Pixel while IDLE: dropped and flagged.
        pixel_valid = 1'b1;
        #1;
        vectors++;
        if ({we1, we2} !== 2'b00) begin
            miscompares++;
            $display("FAIL idle_pixel_we: got we=%b%b want 00", we1, we2);
        end
        @(posedge clk); #1;
        pixel_valid = 1'b0;
        vectors++;
        if ({overrun, frame_req} !== 2'b10) begin
            miscompares++;
            $display("FAIL idle_overrun: got ovr=%b req=%b want 1 0", overrun, frame_req);
        end
        enable = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({frame_req, bank_sel} !== 2'b10) begin
            miscompares++;
            $display("FAIL restart_req: got req=%b sel=%b want 1 0", frame_req, bank_sel);
        end
        for (int i = 0; i < 3; i++) begin
            pixel_valid = 1'b1;
            #1;
            vectors++;
            pobs = {we1, we2, x_pos, y_pos};
            pexp = {1'b1, 1'b0, 8'(i), 8'd0};
            if (pobs !== pexp) begin
                miscompares++;
                $display("FAIL restart_pixel %0d: got we=%b%b x=%0d y=%0d want we=10 x=%0d y=0",
                         i, we1, we2, x_pos, y_pos, i);
            end
            @(posedge clk); #1;
        end
        pixel_valid = 1'b0;
        $display("test_reset_midfill done");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_enable_req();
        test_fill_bank1();
        test_swap();
        test_fill_bank2();
        test_swap_with_pixel();
        test_reset_midfill();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
